// File: rtl/sprite_fetch_if.sv
// Request/acknowledge bus between the sprite fetch sequencer and sprite memory.
// The sequencer drives the request side; memory answers with ack and data.
interface sprite_fetch_if #(
    parameter int IDX_W  = 5,
    parameter int WORD_W = 1
) ();
    logic              fetch_req;
    logic [IDX_W-1:0]  fetch_index;
    logic [WORD_W-1:0] fetch_word;
    logic              mem_ack;
    logic [31:0]       mem_data;

    modport master (
        output fetch_req, fetch_index, fetch_word,
        input  mem_ack, mem_data
    );

    modport slave (
        input  fetch_req, fetch_index, fetch_word,
        output mem_ack, mem_data
    );
endinterface

// File: rtl/sprite_fetch_sequencer.sv
// HBLANK sprite line fetch: req/ack sequencing into the per-sprite line buffers.
// Optional SPRITE_FETCH_STATS_EN adds a saturating per-line overrun counter.
//
// state  | meaning
// IDLE   | waiting for the fetch window at H_ACTIVE+SORT_TIME
// REQ    | fetch_req high, index/word held until mem_ack
// GAP    | request dropped, down-counting inter-request idle cycles
// DONE   | line finished or aborted, waiting for column 0
module sprite_fetch_sequencer #(
    parameter int NUM_SPRITES    = 16,
    parameter int WORDS_PER_LINE = 2,
    parameter int IDX_W          = 5,
    parameter int WORD_W         = 1,
    parameter int H_ACTIVE       = 640,
    parameter int SORT_TIME      = 64,
    parameter int H_TOTAL        = 800,
    parameter int FETCH_GAP      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       pix_col,
    input  logic [IDX_W-1:0]  sprite_count,
    sprite_fetch_if.master    fetch,
    output logic              line_wr,
    output logic [IDX_W-1:0]  line_wr_index,
    output logic [WORD_W-1:0] line_wr_word,
    output logic [31:0]       line_data,
    output logic              fetch_done,
    output logic              fetch_overrun,
    output logic [15:0]       overrun_count
);
    localparam logic [11:0]       WIN_COL   = 12'(H_ACTIVE + SORT_TIME);
    localparam logic [11:0]       END_COL   = 12'(H_TOTAL - 1);
    localparam logic [IDX_W-1:0]  SENTINEL  = IDX_W'(NUM_SPRITES);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);
    localparam int                GAP_W     = (FETCH_GAP > 0) ? $clog2(FETCH_GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] n_lat;
    logic [IDX_W-1:0] n_clamped;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_word;
    logic             abort;

    // An ack on the final word in the last column completes the line rather than aborting it.
    always_comb begin
        n_clamped = (sprite_count > SENTINEL) ? SENTINEL : sprite_count;
        last_word = (fetch.fetch_index == n_lat - IDX_W'(1)) && (fetch.fetch_word == LAST_WORD);
        abort     = (pix_col == END_COL) &&
                    ((state == S_GAP) || ((state == S_REQ) && !(fetch.mem_ack && last_word)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            n_lat             <= '0;
            gap_cnt           <= '0;
            fetch.fetch_req   <= 1'b0;
            fetch.fetch_index <= SENTINEL;
            fetch.fetch_word  <= '0;
            line_wr           <= 1'b0;
            line_wr_index     <= '0;
            line_wr_word      <= '0;
            line_data         <= '0;
            fetch_done        <= 1'b0;
            fetch_overrun     <= 1'b0;
        end else begin
            line_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pix_col == WIN_COL) begin
                        n_lat            <= n_clamped;
                        fetch.fetch_word <= '0;
                        if (n_clamped == '0) begin
                            state             <= S_DONE;
                            fetch_done        <= 1'b1;
                            fetch.fetch_index <= SENTINEL;
                        end else begin
                            state             <= S_REQ;
                            fetch.fetch_req   <= 1'b1;
                            fetch.fetch_index <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (fetch.mem_ack) begin
                        line_wr         <= 1'b1;
                        line_wr_index   <= fetch.fetch_index;
                        line_wr_word    <= fetch.fetch_word;
                        line_data       <= fetch.mem_data;
                        fetch.fetch_req <= 1'b0;
                    end
                    if (fetch.mem_ack && last_word) begin
                        state             <= S_DONE;
                        fetch_done        <= 1'b1;
                        fetch.fetch_index <= SENTINEL;
                        fetch.fetch_word  <= '0;
                    end else if (abort) begin
                        state             <= S_DONE;
                        fetch_overrun     <= 1'b1;
                        fetch.fetch_req   <= 1'b0;
                        fetch.fetch_index <= SENTINEL;
                        fetch.fetch_word  <= '0;
                    end else if (fetch.mem_ack) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_W'(FETCH_GAP);
                        if (fetch.fetch_word == LAST_WORD) begin
                            fetch.fetch_word  <= '0;
                            fetch.fetch_index <= fetch.fetch_index + IDX_W'(1);
                        end else begin
                            fetch.fetch_word  <= fetch.fetch_word + WORD_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state             <= S_DONE;
                        fetch_overrun     <= 1'b1;
                        fetch.fetch_index <= SENTINEL;
                        fetch.fetch_word  <= '0;
                    end else if (gap_cnt == '0) begin
                        state           <= S_REQ;
                        fetch.fetch_req <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    if (pix_col == 12'd0) begin
                        state         <= S_IDLE;
                        fetch_done    <= 1'b0;
                        fetch_overrun <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SPRITE_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_count <= '0;
        end else if (abort && (overrun_count != 16'hFFFF)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end
`else
    assign overrun_count = '0;
`endif
endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Bench for sprite_fetch_sequencer: two instances (FETCH_GAP 0 and 2) share the
// column counter; a timing model predicts writes, completion and aborts per line.
module tb_sprite_fetch_sequencer;
    localparam int NS     = 16;
    localparam int WPL    = 2;
    localparam int NLINES = 7;
    localparam int FIRST  = 705;  // first column seen with the window open
    localparam int LASTC  = 799;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pix_col;
    logic [4:0]  sprite_count;
    int          line, col;
    int          n_cmp = 0;
    int          n_fail = 0;

    int cfg_cnt [NLINES] = '{16, 0, 20, 16, 16, 5, 16};
    int cfg_d0  [NLINES] = '{0, 0, 0, 5, 0, 0, 0};
    int cfg_d1  [NLINES] = '{5, 5, 0, 5, 1, 0, 5};
    int cfg_rc  [NLINES] = '{0, 0, 0, 0, 719, 0, 0};
    int cfg_sp  [NLINES] = '{0, 1, 0, 0, 0, 1, 0};

    logic        req_a [2], ack_a [2], wr_a [2], done_a [2], ovr_a [2];
    logic [4:0]  idx_a [2], lwi_a [2];
    logic [0:0]  wd_a [2], lww_a [2];
    logic [31:0] data_a [2], ld_a [2];
    logic [15:0] ovc_a [2];

    always #5 clk = ~clk;

    sprite_fetch_if #(.IDX_W(5), .WORD_W(1)) bus0 ();
    sprite_fetch_if #(.IDX_W(5), .WORD_W(1)) bus1 ();

    sprite_fetch_sequencer #(.FETCH_GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .pix_col(pix_col), .sprite_count(sprite_count),
        .fetch(bus0.master), .line_wr(wr_a[0]), .line_wr_index(lwi_a[0]),
        .line_wr_word(lww_a[0]), .line_data(ld_a[0]), .fetch_done(done_a[0]),
        .fetch_overrun(ovr_a[0]), .overrun_count(ovc_a[0])
    );
    sprite_fetch_sequencer #(.FETCH_GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .pix_col(pix_col), .sprite_count(sprite_count),
        .fetch(bus1.master), .line_wr(wr_a[1]), .line_wr_index(lwi_a[1]),
        .line_wr_word(lww_a[1]), .line_data(ld_a[1]), .fetch_done(done_a[1]),
        .fetch_overrun(ovr_a[1]), .overrun_count(ovc_a[1])
    );

    assign req_a[0] = bus0.fetch_req;
    assign idx_a[0] = bus0.fetch_index;
    assign wd_a[0]  = bus0.fetch_word;
    assign bus0.mem_ack  = ack_a[0];
    assign bus0.mem_data = data_a[0];
    assign req_a[1] = bus1.fetch_req;
    assign idx_a[1] = bus1.fetch_index;
    assign wd_a[1]  = bus1.fetch_word;
    assign bus1.mem_ack  = ack_a[1];
    assign bus1.mem_data = data_a[1];

    function automatic int raw_cnt(int ln);
        return (ln < NLINES) ? cfg_cnt[ln] : 0;
    endfunction
    function automatic int n_of(int ln);
        return (raw_cnt(ln) > NS) ? NS : raw_cnt(ln);
    endfunction
    function automatic int dly_of(int k, int ln);
        if (ln >= NLINES) return 0;
        return (k == 0) ? cfg_d0[ln] : cfg_d1[ln];
    endfunction
    function automatic int gap_of(int k);
        return (k == 0) ? 0 : 2;
    endfunction
    function automatic int rcol_of(int ln);
        return (ln < NLINES) ? cfg_rc[ln] : 0;
    endfunction
    function automatic int period(int k, int ln);
        return dly_of(k, ln) + gap_of(k) + 2;
    endfunction
    function automatic logic [31:0] mem_word(int ln, int idx, int wd);
        return 32'hA000_005C | (32'(ln & 15) << 24) | (32'(idx & 255) << 16) | (32'(wd & 255) << 8);
    endfunction

    // Word w is acked in column FIRST + w*period + dly; it lands only if that column is
    // no later than the last column of the line (or the column before a reset).
    function automatic int exp_w(int k, int ln);
        int total, lim, c;
        total = n_of(ln) * WPL;
        lim   = (rcol_of(ln) != 0) ? rcol_of(ln) - 1 : LASTC;
        c     = 0;
        for (int w = 0; w < total; w++)
            if (FIRST + w * period(k, ln) + dly_of(k, ln) <= lim) c++;
        return c;
    endfunction
    function automatic bit aborted(int k, int ln);
        return (rcol_of(ln) == 0) && (exp_w(k, ln) < n_of(ln) * WPL);
    endfunction
    function automatic bit completed(int k, int ln);
        return (rcol_of(ln) == 0) && (exp_w(k, ln) == n_of(ln) * WPL);
    endfunction
    function automatic int done_col(int k, int ln);
        int total;
        total = n_of(ln) * WPL;
        if (total == 0) return FIRST;
        return FIRST + (total - 1) * period(k, ln) + dly_of(k, ln) + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (line %0d col %0d)", name, act, exp, line, col);
        end
    endtask

    // Column driver, reset pulses and memory responder.
    int age [2];
    initial begin
        rst = 1'b1;
        line = 0;
        col = 0;
        pix_col = 12'd0;
        sprite_count = 5'(raw_cnt(0));
        for (int k = 0; k < 2; k++) begin
            ack_a[k] = 1'b0;
            data_a[k] = 32'h0;
            age[k] = 0;
        end
        while (!(line == NLINES && col == 3)) begin
            @(posedge clk);
            #1;
            col++;
            if (col == 800) begin
                col = 0;
                line++;
            end
            pix_col = 12'(col);
            rst = (line == 0 && col < 3) || (rcol_of(line) != 0 && col == rcol_of(line));
            if (col == 0) sprite_count = 5'(raw_cnt(line));
            if (line == 2 && col == 720) sprite_count = 5'd3;
            for (int k = 0; k < 2; k++) begin
                if (req_a[k]) begin
                    if (age[k] == dly_of(k, line)) begin
                        ack_a[k]  = 1'b1;
                        data_a[k] = mem_word(line, int'(idx_a[k]), int'(wd_a[k]));
                        age[k]    = 0;
                    end else begin
                        ack_a[k] = 1'b0;
                        age[k]++;
                    end
                end else begin
                    age[k]    = 0;
                    ack_a[k]  = (line < NLINES) && (cfg_sp[line] != 0) &&
                                ((col >= 100 && col <= 110) || col >= FIRST);
                    data_a[k] = 32'hDEAD_BEEF;
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    int          wr_cnt [2] = '{0, 0};
    int          last_idx [2] = '{0, 0};
    int          ovc_exp [2] = '{0, 0};
    logic        p_req [2] = '{1'b0, 1'b0};
    logic        p_ack [2] = '{1'b0, 1'b0};
    logic [4:0]  p_idx [2];
    logic [0:0]  p_wd [2];

    task automatic check_cycle(input int k);
        int    pl, e;
        string t;
        t = $sformatf("i%0d", k);
        if (col == 0 && line > 0) begin
            pl = line - 1;
            chk({t, ".wr_count"}, 32'(wr_cnt[k]), 32'(exp_w(k, pl)));
            chk({t, ".overrun"}, 32'(ovr_a[k]), 32'(aborted(k, pl)));
            chk({t, ".done_at_col0"}, 32'(done_a[k]), 32'(completed(k, pl)));
            if (aborted(k, pl) && ovc_exp[k] < 65535) ovc_exp[k]++;
`ifdef SPRITE_FETCH_STATS_EN
            chk({t, ".overrun_count"}, 32'(ovc_a[k]), 32'(ovc_exp[k]));
            if (k == 1 && pl == 0) chk("lit.ovc_after_line0", 32'(ovc_a[k]), 32'd1);
            if (k == 1 && pl == 2) chk("lit.ovc_after_line2", 32'(ovc_a[k]), 32'd2);
            if (k == 1 && pl == 6) chk("lit.ovc_after_reset", 32'(ovc_a[k]), 32'd1);
`else
            chk({t, ".overrun_count"}, 32'(ovc_a[k]), 32'd0);
`endif
            if (k == 0 && pl == 0) chk("lit.i0_line0_writes", 32'(wr_cnt[k]), 32'd32);
            if (k == 1 && pl == 0) chk("lit.i1_line0_writes", 32'(wr_cnt[k]), 32'd10);
            if (k == 1 && pl == 2) chk("lit.i1_line2_writes", 32'(wr_cnt[k]), 32'd24);
            if (k == 0 && pl == 2) chk("lit.i0_clamp_last_idx", 32'(last_idx[k]), 32'd15);
            if (k == 0 && pl == 4) chk("lit.i0_reset_writes", 32'(wr_cnt[k]), 32'd7);
            if (k == 1 && pl == 4) chk("lit.i1_reset_writes", 32'(wr_cnt[k]), 32'd3);
            wr_cnt[k] = 0;
        end
        if (line >= NLINES) return;

        if (wr_a[k]) begin
            e = wr_cnt[k];
            if (e < exp_w(k, line)) begin
                chk({t, ".wr_idx"}, 32'(lwi_a[k]), 32'(e / WPL));
                chk({t, ".wr_word"}, 32'(lww_a[k]), 32'(e % WPL));
                chk({t, ".wr_data"}, ld_a[k], mem_word(line, e / WPL, e % WPL));
            end else begin
                chk({t, ".stray_wr"}, 32'd1, 32'd0);
            end
            last_idx[k] = int'(lwi_a[k]);
            wr_cnt[k]++;
        end

        if (col >= 1 && col <= 704) begin
            chk({t, ".idle_req"}, 32'(req_a[k]), 32'd0);
            chk({t, ".idle_idx"}, 32'(idx_a[k]), 32'(NS));
            chk({t, ".idle_done"}, 32'(done_a[k]), 32'd0);
            chk({t, ".idle_ovr"}, 32'(ovr_a[k]), 32'd0);
        end
        if (line == 0 && col == 1) begin
            chk({t, ".rst_wr"}, 32'(wr_a[k]), 32'd0);
            chk({t, ".rst_word"}, 32'(wd_a[k]), 32'd0);
            chk({t, ".rst_data"}, ld_a[k], 32'd0);
            chk({t, ".rst_ovc"}, 32'(ovc_a[k]), 32'd0);
        end
        if (col == FIRST) begin
            chk({t, ".start_done"}, 32'(done_a[k]), 32'(n_of(line) == 0));
            chk({t, ".start_req"}, 32'(req_a[k]), 32'(n_of(line) != 0));
        end
        if (completed(k, line) && n_of(line) != 0) begin
            if (col == done_col(k, line) - 1) chk({t, ".done_early"}, 32'(done_a[k]), 32'd0);
            if (col == done_col(k, line)) begin
                chk({t, ".done_rise"}, 32'(done_a[k]), 32'd1);
                chk({t, ".done_sentinel"}, 32'(idx_a[k]), 32'(NS));
            end
        end
        if (k == 0 && line == 0 && col == 768) chk("lit.i0_done_col768", 32'(done_a[k]), 32'd1);
        if (k == 0 && line == 0 && col == 767) chk("lit.i0_done_col767", 32'(done_a[k]), 32'd0);
        if (rcol_of(line) != 0 && col == rcol_of(line) + 1) begin
            ovc_exp[k] = 0;
            chk({t, ".mrst_req"}, 32'(req_a[k]), 32'd0);
            chk({t, ".mrst_idx"}, 32'(idx_a[k]), 32'(NS));
            chk({t, ".mrst_word"}, 32'(wd_a[k]), 32'd0);
            chk({t, ".mrst_wr"}, 32'(wr_a[k]), 32'd0);
            chk({t, ".mrst_done"}, 32'(done_a[k]), 32'd0);
            chk({t, ".mrst_ovr"}, 32'(ovr_a[k]), 32'd0);
            chk({t, ".mrst_data"}, ld_a[k], 32'd0);
            chk({t, ".mrst_ovc"}, 32'(ovc_a[k]), 32'd0);
        end
        if (p_req[k] && !p_ack[k] && req_a[k]) begin
            chk({t, ".hold_idx"}, 32'(idx_a[k]), 32'(p_idx[k]));
            chk({t, ".hold_word"}, 32'(wd_a[k]), 32'(p_wd[k]));
        end
        p_req[k] = req_a[k];
        p_ack[k] = ack_a[k];
        p_idx[k] = idx_a[k];
        p_wd[k]  = wd_a[k];
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) check_cycle(k);
        end
    end
endmodule
